// File: rtl/ddr2_seq_pkg.sv
// Shared definitions for the DDR2 clock/reset sequencer: state encodings,
// output widths and a helper that sizes the shared timer.
package ddr2_seq_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned RETRY_W  = 2;
    localparam int unsigned RELOCK_W = 8;

    localparam int unsigned DEF_DCM_RST_CYCLES  = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT    = 65535;
    localparam int unsigned DEF_MAX_RETRIES     = 3;
    localparam int unsigned DEF_IDLY_RST_CYCLES = 12;
    localparam int unsigned DEF_STABLE_CYCLES   = 256;

    typedef enum logic [STATE_W-1:0] {
        ST_DCM_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_IDLY_RST  = 3'd2,
        ST_WAIT_RDY  = 3'd3,
        ST_STABLE    = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAIL      = 3'd6
    } seq_state_e;

    // Timer holds N-1 for the largest N, so clog2 of the largest N is enough.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ddr2_clk_rst_sequencer_if.sv
// Signals between the clock/reset sequencer and the DCM / IDELAYCTRL / controller.
interface ddr2_clk_rst_sequencer_if;

    logic                                dcm_lock;
    logic                                idelay_ctrl_rdy;
    logic                                dcm_rst;
    logic                                idelayctrl_rst;
    logic                                ctrl_rst;
    logic                                init_done;
    logic                                lock_fail;
    logic [ddr2_seq_pkg::RETRY_W-1:0]    retry_cnt;
    logic [ddr2_seq_pkg::RELOCK_W-1:0]   relock_cnt;
    logic [ddr2_seq_pkg::STATE_W-1:0]    seq_state;

    modport master (
        input  dcm_lock, idelay_ctrl_rdy,
        output dcm_rst, idelayctrl_rst, ctrl_rst, init_done, lock_fail,
               retry_cnt, relock_cnt, seq_state
    );

    modport slave (
        output dcm_lock, idelay_ctrl_rdy,
        input  dcm_rst, idelayctrl_rst, ctrl_rst, init_done, lock_fail,
               retry_cnt, relock_cnt, seq_state
    );

endinterface

// File: rtl/ddr2_sync2.sv
// Two-flop synchroniser for a single asynchronous level, async active-low reset.
module ddr2_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ddr2_clk_rst_sequencer.sv
// Power-up / recovery sequencer: DCM reset and lock with retries, IDELAYCTRL
// reset and ready, controller stabilisation hold, then lock/ready monitoring.
module ddr2_clk_rst_sequencer
    import ddr2_seq_pkg::*;
#(
    parameter int unsigned DCM_RST_CYCLES  = DEF_DCM_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES,
    parameter int unsigned IDLY_RST_CYCLES = DEF_IDLY_RST_CYCLES,
    parameter int unsigned STABLE_CYCLES   = DEF_STABLE_CYCLES
) (
    input  logic                      clk_200,
    input  logic                      sys_reset_in_n,
    ddr2_clk_rst_sequencer_if.master  seq
);

    localparam int unsigned TMR_W = timer_width(DCM_RST_CYCLES, LOCK_TIMEOUT,
                                                IDLY_RST_CYCLES, STABLE_CYCLES);

    localparam logic [TMR_W-1:0]   DCM_LOAD    = TMR_W'(DCM_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   LOCK_LOAD   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   IDLY_LOAD   = TMR_W'(IDLY_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   STABLE_LOAD = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    logic lock_s;
    logic rdy_s;

    ddr2_sync2 u_sync_lock (
        .clk_i  (clk_200),
        .rst_ni (sys_reset_in_n),
        .d_i    (seq.dcm_lock),
        .q_o    (lock_s)
    );

    ddr2_sync2 u_sync_rdy (
        .clk_i  (clk_200),
        .rst_ni (sys_reset_in_n),
        .d_i    (seq.idelay_ctrl_rdy),
        .q_o    (rdy_s)
    );

    seq_state_e          state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                dcm_rst_q, dcm_rst_d;
    logic                idly_rst_q, idly_rst_d;
    logic                ctrl_rst_q, ctrl_rst_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic                tmr_zero;
    logic [RELOCK_W-1:0] relock_inc;

    assign tmr_zero   = (tmr_q == '0);
    assign relock_inc = (relock_q == '1) ? relock_q : relock_q + RELOCK_W'(1);

    always_ff @(posedge clk_200 or negedge sys_reset_in_n) begin
        if (!sys_reset_in_n) begin
            state_q    <= ST_DCM_RST;
            tmr_q      <= DCM_LOAD;
            retry_q    <= '0;
            relock_q   <= '0;
            dcm_rst_q  <= 1'b1;
            idly_rst_q <= 1'b1;
            ctrl_rst_q <= 1'b1;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            retry_q    <= retry_d;
            relock_q   <= relock_d;
            dcm_rst_q  <= dcm_rst_d;
            idly_rst_q <= idly_rst_d;
            ctrl_rst_q <= ctrl_rst_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        retry_d  = retry_q;
        relock_d = relock_q;

        case (state_q)
            ST_DCM_RST: begin
                if (tmr_zero) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle still counts as a lock.
                if (lock_s) begin
                    state_d = ST_IDLY_RST;
                end else if (tmr_zero) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_DCM_RST;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_IDLY_RST: begin
                if (!lock_s)       state_d = ST_DCM_RST;
                else if (tmr_zero) state_d = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (!lock_s)    state_d = ST_DCM_RST;
                else if (rdy_s) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_DCM_RST;
                end else if (!rdy_s) begin
                    state_d = ST_IDLY_RST;
                end else if (tmr_zero) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    relock_d = relock_inc;
                    retry_d  = '0;
                    state_d  = ST_DCM_RST;
                end else if (!rdy_s) begin
                    relock_d = relock_inc;
                    state_d  = ST_IDLY_RST;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_DCM_RST;
            end
        endcase

        // Every state change reloads the timer for the state being entered.
        if (state_d != state_q) begin
            case (state_d)
                ST_DCM_RST:   tmr_d = DCM_LOAD;
                ST_WAIT_LOCK: tmr_d = LOCK_LOAD;
                ST_IDLY_RST:  tmr_d = IDLY_LOAD;
                ST_STABLE:    tmr_d = STABLE_LOAD;
                default:      tmr_d = '0;
            endcase
        end else if (!tmr_zero) begin
            tmr_d = tmr_q - TMR_W'(1);
        end

        dcm_rst_d  = (state_d == ST_DCM_RST);
        idly_rst_d = (state_d == ST_DCM_RST) || (state_d == ST_WAIT_LOCK) ||
                     (state_d == ST_IDLY_RST) || (state_d == ST_FAIL);
        ctrl_rst_d = (state_d != ST_RUN);
        done_d     = (state_d == ST_RUN);
        fail_d     = (state_d == ST_FAIL);
    end

    assign seq.dcm_rst        = dcm_rst_q;
    assign seq.idelayctrl_rst = idly_rst_q;
    assign seq.ctrl_rst       = ctrl_rst_q;
    assign seq.init_done      = done_q;
    assign seq.lock_fail      = fail_q;
    assign seq.retry_cnt      = retry_q;
    assign seq.relock_cnt     = relock_q;
    assign seq.seq_state      = state_q;

endmodule

// File: tb/tb_ddr2_clk_rst_sequencer.sv
// Directed bench for ddr2_clk_rst_sequencer with shortened timing parameters.
module tb_ddr2_clk_rst_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ddr2_clk_rst_sequencer_if seq_if ();

    ddr2_clk_rst_sequencer #(
        .DCM_RST_CYCLES  (4),
        .LOCK_TIMEOUT    (20),
        .MAX_RETRIES     (2),
        .IDLY_RST_CYCLES (3),
        .STABLE_CYCLES   (8)
    ) dut (
        .clk_200        (clk),
        .sys_reset_in_n (rst_n),
        .seq            (seq_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         rst;
        logic       lock;
        logic       rdy;
        int         cyc;
        logic [2:0] st;
        logic [1:0] retry;
        logic [7:0] relock;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   rise_cnt = 0;
    logic dcm_prev = 1'b0;

    // Counts dcm_rst rising edges as seen on the falling clock edge.
    always @(negedge clk) begin
        if (seq_if.dcm_rst && !dcm_prev) rise_cnt++;
        dcm_prev = seq_if.dcm_rst;
    end

    task automatic add(input string n, input bit r, input logic l, input logic y,
                       input int c, input logic [2:0] s, input logic [1:0] rt,
                       input logic [7:0] rl);
        vec_t v;
        v.name = n; v.rst = r; v.lock = l; v.rdy = y; v.cyc = c;
        v.st = s; v.retry = rt; v.relock = rl;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic l, input logic y);
        seq_if.dcm_lock        = l;
        seq_if.idelay_ctrl_rdy = y;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Expected output decodes follow from the expected state.
    task automatic check(input string n, input logic [2:0] st, input logic [1:0] rt,
                         input logic [7:0] rl);
        logic [18:0] got, exp;
        logic e_dcm, e_idly, e_ctrl, e_done, e_fail;
        e_dcm  = (st == 3'd0);
        e_idly = (st == 3'd0) || (st == 3'd1) || (st == 3'd2) || (st == 3'd6);
        e_ctrl = (st != 3'd5);
        e_done = (st == 3'd5);
        e_fail = (st == 3'd6);
        exp = {st, e_dcm, e_idly, e_ctrl, e_done, e_fail, rt, rl};
        got = {seq_if.seq_state, seq_if.dcm_rst, seq_if.idelayctrl_rst, seq_if.ctrl_rst,
               seq_if.init_done, seq_if.lock_fail, seq_if.retry_cnt, seq_if.relock_cnt};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got st=%0d dcm=%b idly=%b ctrl=%b done=%b fail=%b retry=%0d relock=%0d, expected st=%0d dcm=%b idly=%b ctrl=%b done=%b fail=%b retry=%0d relock=%0d",
                     n, got[18:16], got[15], got[14], got[13], got[12], got[11], got[10:9], got[7:0],
                     st, e_dcm, e_idly, e_ctrl, e_done, e_fail, rt, rl);
        end
    endtask

    initial begin
        int base;
        seq_if.dcm_lock        = 1'b0;
        seq_if.idelay_ctrl_rdy = 1'b1;

        // Nominal bring-up
        add("nom_reset",      1, 0, 1, 0, 3'd0, 2'd0, 8'd0);
        add("nom_dcm_hold",   0, 0, 1, 3, 3'd0, 2'd0, 8'd0);
        add("nom_dcm_exit",   0, 0, 1, 1, 3'd1, 2'd0, 8'd0);
        add("nom_wait_lock",  0, 0, 1, 6, 3'd1, 2'd0, 8'd0);
        add("nom_lock_sync",  0, 1, 1, 2, 3'd1, 2'd0, 8'd0);
        add("nom_idly_entry", 0, 1, 1, 1, 3'd2, 2'd0, 8'd0);
        add("nom_idly_hold",  0, 1, 1, 2, 3'd2, 2'd0, 8'd0);
        add("nom_wait_rdy",   0, 1, 1, 1, 3'd3, 2'd0, 8'd0);
        add("nom_stable",     0, 1, 1, 1, 3'd4, 2'd0, 8'd0);
        add("nom_stable_end", 0, 1, 1, 7, 3'd4, 2'd0, 8'd0);
        add("nom_run",        0, 1, 1, 1, 3'd5, 2'd0, 8'd0);
        // Lock loss in RUN, 5-cycle drop
        add("ll_sync_delay",  0, 0, 1, 2, 3'd5, 2'd0, 8'd0);
        add("ll_to_dcm",      0, 0, 1, 1, 3'd0, 2'd0, 8'd1);
        add("ll_dcm_hold",    0, 0, 1, 2, 3'd0, 2'd0, 8'd1);
        add("ll_wait_lock",   0, 1, 1, 2, 3'd1, 2'd0, 8'd1);
        add("ll_idly",        0, 1, 1, 1, 3'd2, 2'd0, 8'd1);
        add("ll_wait_rdy",    0, 1, 1, 3, 3'd3, 2'd0, 8'd1);
        add("ll_stable",      0, 1, 1, 1, 3'd4, 2'd0, 8'd1);
        add("ll_run",         0, 1, 1, 8, 3'd5, 2'd0, 8'd1);
        // Ready loss in RUN
        add("rl_sync_delay",  0, 1, 0, 2, 3'd5, 2'd0, 8'd1);
        add("rl_to_idly",     0, 1, 0, 1, 3'd2, 2'd0, 8'd2);
        add("rl_idly_hold",   0, 1, 1, 2, 3'd2, 2'd0, 8'd2);
        add("rl_wait_rdy",    0, 1, 1, 1, 3'd3, 2'd0, 8'd2);
        add("rl_stable",      0, 1, 1, 1, 3'd4, 2'd0, 8'd2);
        add("rl_run",         0, 1, 1, 8, 3'd5, 2'd0, 8'd2);
        // One timeout, lock on the second attempt
        add("to_reset",       1, 0, 1, 0, 3'd0, 2'd0, 8'd0);
        add("to_wait_lock",   0, 0, 1, 4, 3'd1, 2'd0, 8'd0);
        add("to_last_wait",   0, 0, 1, 19, 3'd1, 2'd0, 8'd0);
        add("to_retry_dcm",   0, 0, 1, 1, 3'd0, 2'd1, 8'd0);
        add("to_dcm_hold",    0, 0, 1, 3, 3'd0, 2'd1, 8'd0);
        add("to_wait2",       0, 0, 1, 1, 3'd1, 2'd1, 8'd0);
        add("to_lock_sync",   0, 1, 1, 2, 3'd1, 2'd1, 8'd0);
        add("to_idly",        0, 1, 1, 1, 3'd2, 2'd1, 8'd0);
        add("to_wait_rdy",    0, 1, 1, 3, 3'd3, 2'd1, 8'd0);
        add("to_stable",      0, 1, 1, 1, 3'd4, 2'd1, 8'd0);
        add("to_run",         0, 1, 1, 8, 3'd5, 2'd0, 8'd0);
        // Lock arrives on the timeout cycle, then lock loss in WAIT_RDY
        add("co_reset",       1, 0, 1, 0, 3'd0, 2'd0, 8'd0);
        add("co_wait_lock",   0, 0, 1, 21, 3'd1, 2'd0, 8'd0);
        add("co_timer_zero",  0, 1, 1, 2, 3'd1, 2'd0, 8'd0);
        add("co_lock_wins",   0, 1, 1, 1, 3'd2, 2'd0, 8'd0);
        add("wr_no_rdy",      0, 1, 0, 3, 3'd3, 2'd0, 8'd0);
        add("wr_no_timeout",  0, 1, 0, 5, 3'd3, 2'd0, 8'd0);
        add("wr_lock_sync",   0, 0, 0, 2, 3'd3, 2'd0, 8'd0);
        add("wr_lock_loss",   0, 0, 0, 1, 3'd0, 2'd0, 8'd0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset(vecs[i].lock, vecs[i].rdy);
            end else begin
                seq_if.dcm_lock        = vecs[i].lock;
                seq_if.idelay_ctrl_rdy = vecs[i].rdy;
            end
            step(vecs[i].cyc);
            check(vecs[i].name, vecs[i].st, vecs[i].retry, vecs[i].relock);
        end

        // Retry exhaustion, sticky failure, async recovery
        do_reset(1'b0, 1'b1);
        base = rise_cnt;
        step(24); check("ex_retry1", 3'd0, 2'd1, 8'd0);
        step(24); check("ex_retry2", 3'd0, 2'd2, 8'd0);
        step(23); check("ex_last_wait", 3'd1, 2'd2, 8'd0);
        step(1);  check("ex_fail", 3'd6, 2'd2, 8'd0);
        seq_if.dcm_lock = 1'b1;
        step(10); check("ex_fail_sticky", 3'd6, 2'd2, 8'd0);
        total++;
        if (1 + rise_cnt - base != 3) begin
            bad++;
            $display("FAIL ex_dcm_pulses: got %0d pulses, expected 3", 1 + rise_cnt - base);
        end
        rst_n = 1'b0;
        #1;
        check("ex_async_rst", 3'd0, 2'd0, 8'd0);
        step(1);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
